// File: rtl/ysyx_041461_if_fetch_pkg.sv
// Shared definitions for the IF fetch bus master:
// FSM state encoding, fetch-fault codes and the default NOP instruction.
package ysyx_041461_if_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  FAULT_NONE     = 2'b00;
  localparam logic [1:0]  FAULT_MISALIGN = 2'b01;
  localparam logic [1:0]  FAULT_BUSERR   = 2'b10;

  localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0013;

endpackage

// File: rtl/ysyx_041461_if_fetch.sv
// Instruction-fetch AXI4-Lite read master: one read per PC, holds the
// extracted 32-bit instruction for IF/ID and drives the PC-register enable.
module ysyx_041461_if_fetch
  import ysyx_041461_if_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       IF_pc,
  input  logic              IF_flush,
  input  logic              IF_ID_ready,
  output logic              IF_pc_en,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  output logic [31:0]       IF_inst,
  output logic [63:0]       IF_inst_pc,
  output logic              IF_inst_valid,
  output logic [1:0]        IF_fault
);

  fetch_state_t state;
  logic [63:0]  req_pc;
  logic         flush_pend;

  assign araddr   = req_pc[ADDR_W-1:0];
  assign rready   = (state == S_DATA);
  assign IF_pc_en = ((state == S_HOLD) && IF_ID_ready) || IF_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      req_pc        <= '0;
      flush_pend    <= 1'b0;
      arvalid       <= 1'b0;
      IF_inst       <= NOP_INST;
      IF_inst_pc    <= '0;
      IF_inst_valid <= 1'b0;
      IF_fault      <= FAULT_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          // A flush here means the PC register loads the redirect on this
          // edge; staying idle makes that new PC the next one fetched.
          if (!IF_flush) begin
            req_pc <= IF_pc;
            if (IF_pc[1:0] != 2'b00) begin
              state         <= S_HOLD;
              IF_inst       <= NOP_INST;
              IF_inst_pc    <= IF_pc;
              IF_fault      <= FAULT_MISALIGN;
              IF_inst_valid <= 1'b1;
            end else begin
              state   <= S_ADDR;
              arvalid <= 1'b1;
            end
          end
        end

        S_ADDR: begin
          if (IF_flush) flush_pend <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            state   <= S_DATA;
          end
        end

        S_DATA: begin
          if (rvalid) begin
            if (flush_pend || IF_flush) begin
              flush_pend <= 1'b0;
              state      <= S_IDLE;
            end else begin
              IF_inst_pc    <= req_pc;
              IF_inst_valid <= 1'b1;
              state         <= S_HOLD;
              if (rresp != 2'b00) begin
                IF_inst  <= NOP_INST;
                IF_fault <= FAULT_BUSERR;
              end else begin
                IF_inst  <= req_pc[2] ? rdata[63:32] : rdata[31:0];
                IF_fault <= FAULT_NONE;
              end
            end
          end else if (IF_flush) begin
            flush_pend <= 1'b1;
          end
        end

        S_HOLD: begin
          if (IF_flush || IF_ID_ready) begin
            IF_inst_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_if_fetch.sv
// Directed and randomized bench for the IF fetch master; expected values
// come from a transaction-level model of each fetch.
module tb_ysyx_041461_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] IF_pc;
  logic        IF_flush;
  logic        IF_ID_ready;
  logic        IF_pc_en;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] IF_inst;
  logic [63:0] IF_inst_pc;
  logic        IF_inst_valid;
  logic [1:0]  IF_fault;

  int errors = 0;
  int checks = 0;

  ysyx_041461_if_fetch #(.ADDR_W(32), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .IF_pc        (IF_pc),
    .IF_flush     (IF_flush),
    .IF_ID_ready  (IF_ID_ready),
    .IF_pc_en     (IF_pc_en),
    .arvalid      (arvalid),
    .arready      (arready),
    .araddr       (araddr),
    .rvalid       (rvalid),
    .rready       (rready),
    .rdata        (rdata),
    .rresp        (rresp),
    .IF_inst      (IF_inst),
    .IF_inst_pc   (IF_inst_pc),
    .IF_inst_valid(IF_inst_valid),
    .IF_fault     (IF_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch from IDLE through hand-off; expectations come from
  // the architectural rules (word select by pc[2], faults force NOP).
  task automatic fetch_one(input logic [63:0] pc, input logic [63:0] data,
                           input logic [1:0] resp, input int unsigned ar_dly,
                           input int unsigned r_dly, input int unsigned hold_dly);
    logic [31:0] exp_inst;
    logic [1:0]  exp_fault;
    if (pc[1:0] != 2'b00) begin
      exp_fault = 2'b01; exp_inst = NOP;
    end else if (resp != 2'b00) begin
      exp_fault = 2'b10; exp_inst = NOP;
    end else begin
      exp_fault = 2'b00; exp_inst = 32'(data >> (pc[2] ? 32 : 0));
    end
    IF_pc = pc; IF_flush = 0; IF_ID_ready = 0; arready = 0; rvalid = 0;
    #1;
    chk("idle_pc_en", 64'(IF_pc_en), 0);
    chk("idle_arvalid", 64'(arvalid), 0);
    step();
    if (exp_fault != 2'b01) begin
      chk("addr_arvalid", 64'(arvalid), 1);
      chk("addr_araddr", 64'(araddr), 64'(pc[31:0]));
      chk("addr_pc_en", 64'(IF_pc_en), 0);
      for (int i = 0; i < int'(ar_dly); i++) begin
        step();
        chk("addr_wait_arvalid", 64'(arvalid), 1);
        chk("addr_wait_araddr", 64'(araddr), 64'(pc[31:0]));
      end
      arready = 1;
      step();
      arready = 0;
      chk("data_rready", 64'(rready), 1);
      chk("data_arvalid", 64'(arvalid), 0);
      chk("data_pc_en", 64'(IF_pc_en), 0);
      for (int i = 0; i < int'(r_dly); i++) begin
        step();
        chk("data_wait_rready", 64'(rready), 1);
        chk("data_wait_valid", 64'(IF_inst_valid), 0);
      end
      rvalid = 1; rdata = data; rresp = resp;
      step();
      rvalid = 0; rdata = {$urandom, $urandom}; rresp = 2'b00;
    end else begin
      chk("mis_arvalid", 64'(arvalid), 0);
    end
    chk("hold_valid", 64'(IF_inst_valid), 1);
    chk("hold_inst", 64'(IF_inst), 64'(exp_inst));
    chk("hold_inst_pc", IF_inst_pc, pc);
    chk("hold_fault", 64'(IF_fault), 64'(exp_fault));
    chk("hold_rready", 64'(rready), 0);
    chk("hold_pc_en", 64'(IF_pc_en), 0);
    for (int i = 0; i < int'(hold_dly); i++) begin
      step();
      chk("stall_valid", 64'(IF_inst_valid), 1);
      chk("stall_inst", 64'(IF_inst), 64'(exp_inst));
      chk("stall_pc_en", 64'(IF_pc_en), 0);
      chk("stall_arvalid", 64'(arvalid), 0);
    end
    IF_ID_ready = 1;
    #1;
    chk("handoff_pc_en", 64'(IF_pc_en), 1);
    step();
    IF_ID_ready = 0;
    #1;
    chk("after_valid", 64'(IF_inst_valid), 0);
    chk("after_pc_en", 64'(IF_pc_en), 0);
  endtask

  initial begin
    logic [63:0] pc;
    logic [1:0]  resp;

    rst = 1; IF_pc = 0; IF_flush = 0; IF_ID_ready = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    #12;
    chk("rst_arvalid", 64'(arvalid), 0);
    chk("rst_rready", 64'(rready), 0);
    chk("rst_valid", 64'(IF_inst_valid), 0);
    chk("rst_pc_en", 64'(IF_pc_en), 0);
    chk("rst_inst", 64'(IF_inst), 64'(NOP));
    chk("rst_inst_pc", IF_inst_pc, 0);
    chk("rst_fault", 64'(IF_fault), 0);
    step();
    rst = 0;

    // Zero-wait fetch, low word, then high word with a 5-cycle stall
    fetch_one(64'h3000_0000, 64'h1111_2222_0010_0093, 2'b00, 0, 0, 0);
    fetch_one(64'h3000_0004, 64'h1111_2222_0010_0093, 2'b00, 0, 0, 5);

    // Flush during ADDR with arready low: arvalid held, beat discarded
    IF_pc = 64'h3000_0008;
    step();
    IF_flush = 1; IF_pc = 64'h3000_0100;
    #1;
    chk("flush_addr_pc_en", 64'(IF_pc_en), 1);
    step();
    IF_flush = 0;
    chk("flush_addr_arvalid", 64'(arvalid), 1);
    chk("flush_addr_araddr", 64'(araddr), 64'h3000_0008);
    step();
    step();
    chk("flush_addr_arvalid2", 64'(arvalid), 1);
    arready = 1;
    step();
    arready = 0;
    chk("flush_data_rready", 64'(rready), 1);
    rvalid = 1; rdata = 64'hdead_beef_cafe_f00d;
    step();
    rvalid = 0;
    chk("flush_discard_valid", 64'(IF_inst_valid), 0);
    chk("flush_discard_rready", 64'(rready), 0);
    chk("flush_discard_arvalid", 64'(arvalid), 0);
    fetch_one(64'h3000_0100, 64'h0000_0000_00a0_0513, 2'b00, 0, 0, 0);

    // Flush in DATA before the beat arrives
    IF_pc = 64'h3000_0200;
    step();
    arready = 1;
    step();
    arready = 0; IF_flush = 1;
    step();
    IF_flush = 0;
    chk("flush_data_pend_rready", 64'(rready), 1);
    rvalid = 1;
    step();
    rvalid = 0;
    chk("flush_data_discard", 64'(IF_inst_valid), 0);
    chk("flush_data_idle", 64'(rready), 0);

    // Flush in IDLE: no fetch starts
    IF_pc = 64'h3000_0300; IF_flush = 1;
    step();
    IF_flush = 0;
    chk("flush_idle_arvalid", 64'(arvalid), 0);

    // Flush in HOLD without IF_ID_ready
    IF_pc = 64'h3000_0306;
    step();
    chk("flush_hold_valid", 64'(IF_inst_valid), 1);
    IF_flush = 1;
    #1;
    chk("flush_hold_pc_en", 64'(IF_pc_en), 1);
    step();
    IF_flush = 0;
    chk("flush_hold_cleared", 64'(IF_inst_valid), 0);

    // Bus error and misaligned PC
    fetch_one(64'h3000_0010, 64'h1234_5678_9abc_def0, 2'b10, 1, 2, 0);
    fetch_one(64'h3000_0002, 64'h0, 2'b00, 0, 0, 1);

    // Asynchronous reset mid-DATA
    IF_pc = 64'h3000_0020;
    step();
    arready = 1;
    step();
    arready = 0;
    chk("mid_rready", 64'(rready), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_rready", 64'(rready), 0);
    chk("async_rst_arvalid", 64'(arvalid), 0);
    chk("async_rst_valid", 64'(IF_inst_valid), 0);
    step();
    rst = 0;
    fetch_one(64'h3000_0020, 64'hffff_0000_0000_0073, 2'b00, 0, 0, 0);

    // Randomized fetches
    for (int n = 0; n < 40; n++) begin
      pc = {$urandom, $urandom & 32'hffff_fffc};
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      fetch_one(pc, {$urandom, $urandom}, resp,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_if_fetch.md
Name: ysyx_041461_if_fetch

Overview:
Instruction-fetch bus master directly downstream of the IF PC register. Takes the current PC and issues one AXI4-Lite read per instruction. It extracts the 32-bit instruction from the 64-bit beat and presents it, with its PC, to the IF/ID pipeline register. It also generates the PC-register enable, so the PC advances only when the instruction is handed off or a redirect (flush) occurs.

Parameters:
ADDR_W, 32, AXI read address width; araddr = req_pc[ADDR_W-1:0].
NOP_INST, 32'h0000_0013, instruction word substituted on any fetch fault.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
IF_pc  in  64  current PC from PC register
IF_flush  in  1  redirect from ID/WB; discard any in-flight fetch
IF_ID_ready  in  1  IF/ID register accepts the held instruction this cycle
IF_pc_en  out  1  drives PC register enable
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
araddr  out  ADDR_W  AXI read address
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
rdata  in  64  AXI read data
rresp  in  2  AXI read response
IF_inst  out  32  fetched instruction
IF_inst_pc  out  64  PC of IF_inst
IF_inst_valid  out  1  IF_inst/IF_inst_pc/IF_fault valid
IF_fault  out  2  00 none, 01 misaligned PC, 10 bus error

Behaviour:
- Reset (async, any state): state=IDLE; arvalid, rready, IF_inst_valid, IF_pc_en, flush_pend = 0; IF_inst = NOP_INST; IF_inst_pc = 0; IF_fault = 00.
- FSM states: IDLE, ADDR, DATA, HOLD. All outputs are registered except IF_pc_en and rready, which are combinational from state and inputs.
- IDLE:
  - If !IF_flush: latch req_pc <= IF_pc.
  - If IF_pc[1:0] != 0: go to HOLD with IF_fault=01, IF_inst=NOP_INST, no bus access.
  - Otherwise go to ADDR.
  - If IF_flush: stay IDLE, so the PC updated on this edge is the one fetched next.
- ADDR:
  - arvalid=1; araddr=req_pc[ADDR_W-1:0], held stable until the handshake.
  - On arvalid & arready: go to DATA.
  - arvalid is never retracted. IF_flush here sets flush_pend.
- DATA:
  - rready=1. IF_flush here also sets flush_pend.
  - On rvalid with (flush_pend | IF_flush): discard the beat, clear flush_pend, go to IDLE.
  - On rvalid otherwise: IF_inst = req_pc[2] ? rdata[63:32] : rdata[31:0]; IF_inst_pc = req_pc; IF_fault = (rresp != 0) ? 10 : 00. On a fault, IF_inst = NOP_INST. Set IF_inst_valid=1 and go to HOLD.
- HOLD:
  - IF_inst_valid=1 with stable outputs.
  - If IF_flush: clear IF_inst_valid, go to IDLE (flush has priority over IF_ID_ready).
  - Else if IF_ID_ready: clear IF_inst_valid, go to IDLE.
- IF_pc_en = (HOLD & IF_ID_ready) | IF_flush.
  - Exactly one pulse per handed-off instruction.
  - A flush always enables the PC register, so a WB/ID redirect loads in any state.
- Latency, zero-wait bus: IDLE(c0) -> ADDR with handshake (c1) -> DATA with rvalid (c2) -> IF_inst_valid=1 at c3. Minimum 4 cycles per instruction with IF_ID_ready tied high.
- One outstanding read maximum; no second arvalid before rvalid of the first.

Decomposition:
- Shared define header: FSM state encodings (2-bit), IF_fault codes (NONE/MISALIGN/BUSERR), and the NOP_INST value.
- Single module; no sub-module. Word select and fault muxing are inline.

Test Plan:
- Reset release, IF_pc=0x3000_0000, arready=rvalid=1 same cycle, rdata=0x1111_2222_0010_0093, rresp=0 -> araddr=0x3000_0000 at c1; IF_inst=0x0010_0093, IF_inst_pc=0x3000_0000, valid at c3; IF_pc_en=1 at c3 only.
- IF_pc=0x3000_0004, same rdata -> IF_inst=0x1111_2222; IF_ID_ready held 0 for 5 cycles -> IF_inst_valid stays 1, outputs stable, IF_pc_en=0 throughout.
- IF_flush pulsed in ADDR while arready=0 for 3 cycles -> arvalid held until handshake; the following rvalid beat is discarded; no IF_inst_valid; next fetch uses the redirected PC.
- rresp=2'b10 on an aligned fetch -> IF_fault=10, IF_inst=0x0000_0013, IF_inst_valid=1.
- IF_pc=0x3000_0002 -> no arvalid ever asserted; IF_fault=01, IF_inst_pc=0x3000_0002, valid after 1 cycle.
- rst asserted mid-DATA -> arvalid, rready, IF_inst_valid drop to 0 asynchronously; FSM restarts from IDLE after release.
